// File: rtl/control_pkg.sv
// Shared encodings for the RV32I control unit: opcodes, control-field enums
// and the bundle of decoded controls that travels through the pipeline register.
package control_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_MEM  = 2'b01,
        RES_PC4  = 2'b10,
        RES_NONE = 2'b11
    } result_src_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        alu_src;
        result_src_e result_src;
        imm_src_e    imm_src;
        alu_ctrl_e   alu_control;
        logic        branch;
        logic        jump;
        logic        bne;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        reg_write:   1'b0,
        mem_write:   1'b0,
        alu_src:     1'b0,
        result_src:  RES_ALU,
        imm_src:     IMM_I,
        alu_control: ALU_ADD,
        branch:      1'b0,
        jump:        1'b0,
        bne:         1'b0
    };

    // Only beq/bne are real branches; other branch funct3 codes must never redirect.
    function automatic logic is_supported_branch(input logic [2:0] f3);
        return (f3 == F3_BEQ) || (f3 == F3_BNE);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Second-level decode: turns ALUOp plus funct3/funct7 into the ALU operation select.
module alu_decoder
    import control_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7_5,
    output logic [2:0] ALUControl
);

    alu_op_e   w_alu_op;
    alu_ctrl_e w_ctrl;

    assign w_alu_op = alu_op_e'(ALUOp);

    always_comb begin
        w_ctrl = ALU_ADD;
        unique case (w_alu_op)
            ALUOP_ADD:  w_ctrl = ALU_ADD;
            ALUOP_SUB:  w_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                unique case (funct3)
                    // funct7_5 only means sub for register-register ops; addi ignores it
                    3'b000:  w_ctrl = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  w_ctrl = ALU_SLT;
                    3'b100:  w_ctrl = ALU_XOR;
                    3'b110:  w_ctrl = ALU_OR;
                    3'b111:  w_ctrl = ALU_AND;
                    default: w_ctrl = ALU_ADD;
                endcase
            end
            default:    w_ctrl = ALU_ADD;
        endcase
    end

    assign ALUControl = w_ctrl;

endmodule

// File: rtl/control_unit.sv
// RV32I control unit: main decode, one registered control stage, and PCSrc
// formed from the registered branch/jump intent and the live ALU zero flag.
module control_unit
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zeroFlag,
    output logic       PCSrc,
    output logic       MemWrite,
    output logic       ALUSrc,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] immSrc,
    output logic [2:0] ALUControl
);

    alu_op_e    w_alu_op;
    logic [2:0] w_alu_control;
    ctrl_t      w_ctrl;
    ctrl_t      r_ctrl;

    always_comb begin
        w_ctrl   = CTRL_NOP;
        w_alu_op = ALUOP_ADD;
        unique case (opcode)
            OP_LOAD: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.imm_src    = IMM_I;
                w_ctrl.result_src = RES_MEM;
                w_alu_op          = ALUOP_ADD;
            end
            OP_STORE: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.imm_src   = IMM_S;
                w_alu_op         = ALUOP_ADD;
            end
            OP_RTYPE: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.alu_src    = 1'b0;
                w_ctrl.result_src = RES_ALU;
                w_alu_op          = ALUOP_FUNCT;
            end
            OP_ITYPE: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.imm_src    = IMM_I;
                w_ctrl.result_src = RES_ALU;
                w_alu_op          = ALUOP_FUNCT;
            end
            OP_BRANCH: begin
                // Unsupported branch funct3 keeps its decode but can never be taken
                w_ctrl.branch  = is_supported_branch(funct3);
                w_ctrl.bne     = (funct3 == F3_BNE);
                w_ctrl.imm_src = IMM_B;
                w_ctrl.alu_src = 1'b0;
                w_alu_op       = ALUOP_SUB;
            end
            OP_JAL: begin
                w_ctrl.jump       = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.imm_src    = IMM_J;
                w_ctrl.result_src = RES_PC4;
                w_alu_op          = ALUOP_ADD;
            end
            default: begin
                w_ctrl   = CTRL_NOP;
                w_alu_op = ALUOP_ADD;
            end
        endcase
        w_ctrl.alu_control = alu_ctrl_e'(w_alu_control);
    end

    alu_decoder u_alu_decoder (
        .ALUOp      (w_alu_op),
        .funct3     (funct3),
        .op5        (opcode[5]),
        .funct7_5   (funct7_5),
        .ALUControl (w_alu_control)
    );

    // Decode -> execute stage boundary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ctrl <= CTRL_NOP;
        end else begin
            r_ctrl <= w_ctrl;
        end
    end

    assign MemWrite   = r_ctrl.mem_write;
    assign ALUSrc     = r_ctrl.alu_src;
    assign RegWrite   = r_ctrl.reg_write;
    assign ResultSrc  = r_ctrl.result_src;
    assign immSrc     = r_ctrl.imm_src;
    assign ALUControl = r_ctrl.alu_control;
    assign PCSrc      = r_ctrl.jump | (r_ctrl.branch & (zeroFlag ^ r_ctrl.bne));

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven check of control_unit decode, PCSrc and reset behaviour.
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zeroFlag;
    logic       PCSrc;
    logic       MemWrite;
    logic       ALUSrc;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] immSrc;
    logic [2:0] ALUControl;

    int n_vec;
    int n_bad;

    control_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .zeroFlag   (zeroFlag),
        .PCSrc      (PCSrc),
        .MemWrite   (MemWrite),
        .ALUSrc     (ALUSrc),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .immSrc     (immSrc),
        .ALUControl (ALUControl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs packed as {PCSrc, MemWrite, ALUSrc, RegWrite, ResultSrc, immSrc, ALUControl}
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        zf;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [11:0] outs();
        return {PCSrc, MemWrite, ALUSrc, RegWrite, ResultSrc, immSrc, ALUControl};
    endfunction

    task automatic drive(input logic [31:0] instr, input logic zf);
        opcode   = instr[6:0];
        funct3   = instr[14:12];
        funct7_5 = instr[30];
        zeroFlag = zf;
    endtask

    task automatic check(input string name, input logic [11:0] exp);
        logic [11:0] got;
        got = outs();
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b (PCSrc,MemWrite,ALUSrc,RegWrite,ResultSrc,immSrc,ALUControl)",
                     name, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        drive(v.instr, v.zf);
        @(posedge clk);
        #1;
        check(v.name, v.exp);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        drive(32'h0000006F, 1'b1);

        vecs.push_back('{"lw",         32'hFFC4A303, 1'b0, 12'b0_0_1_1_01_00_000});
        vecs.push_back('{"sw",         32'h0064A423, 1'b0, 12'b0_1_1_0_00_01_000});
        vecs.push_back('{"or",         32'h0062E233, 1'b0, 12'b0_0_0_1_00_00_011});
        vecs.push_back('{"beq_z1",     32'hFE420AE3, 1'b1, 12'b1_0_0_0_00_10_001});
        vecs.push_back('{"beq_z0",     32'hFE420AE3, 1'b0, 12'b0_0_0_0_00_10_001});
        vecs.push_back('{"sub",        32'h40000033, 1'b0, 12'b0_0_0_1_00_00_001});
        vecs.push_back('{"addi_f7",    32'h40008093, 1'b0, 12'b0_0_1_1_00_00_000});
        vecs.push_back('{"jal",        32'h0000006F, 1'b0, 12'b1_0_0_1_10_11_000});
        vecs.push_back('{"illegal",    32'h0000007F, 1'b1, 12'b0_0_0_0_00_00_000});
        vecs.push_back('{"xor",        32'h0062C233, 1'b0, 12'b0_0_0_1_00_00_100});
        vecs.push_back('{"slt",        32'h0062A233, 1'b0, 12'b0_0_0_1_00_00_101});
        vecs.push_back('{"and",        32'h0062F233, 1'b0, 12'b0_0_0_1_00_00_010});
        vecs.push_back('{"sll_as_add", 32'h00629233, 1'b1, 12'b0_0_0_1_00_00_000});
        vecs.push_back('{"bne_z0",     32'h00209463, 1'b0, 12'b1_0_0_0_00_10_001});
        vecs.push_back('{"bne_z1",     32'h00209463, 1'b1, 12'b0_0_0_0_00_10_001});
        vecs.push_back('{"br_f3_010",  32'h0000A063, 1'b1, 12'b0_0_0_0_00_10_001});
        vecs.push_back('{"jal_z1",     32'h0000006F, 1'b1, 12'b1_0_0_1_10_11_000});

        // Reset held for two edges with a jal applied and zeroFlag high
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_hold", 12'b0);

        @(negedge clk);
        rst_n = 1'b1;
        foreach (vecs[i]) apply(vecs[i]);

        // Same beq, zeroFlag falls within the cycle: PCSrc must follow without an edge
        apply('{"beq_toggle_z1", 32'hFE420AE3, 1'b1, 12'b1_0_0_0_00_10_001});
        zeroFlag = 1'b0;
        #1;
        check("beq_toggle_z0", 12'b0_0_0_0_00_10_001);

        // Mid-stream reset drops the instruction in flight
        apply('{"pre_rst_jal", 32'h0000006F, 1'b1, 12'b1_0_0_1_10_11_000});
        @(negedge clk);
        rst_n = 1'b0;
        drive(32'hFFC4A303, 1'b1);
        @(posedge clk);
        #1;
        check("midstream_reset", 12'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("lw_after_reset", 12'b0_0_1_1_01_00_000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction decoder for the tiny RV32I core. It sits between instruction fetch and the datapath: it decodes `opcode`/`funct3`/`funct7_5` into datapath controls, registers them for one stage, and drives `PCSrc` from the registered branch/jump intent and the live ALU `zeroFlag`. The supported subset is lw, sw, R-type ALU, I-type ALU, beq, bne and jal.

## Interface
No parameters.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `opcode`  in  7  instruction[6:0].
- `funct3`  in  3  instruction[14:12].
- `funct7_5`  in  1  instruction[30].
- `zeroFlag`  in  1  ALU result == 0, from the execute stage, same cycle as the registered controls.
- `PCSrc`  out  1  1 = take the branch/jump target.
- `MemWrite`  out  1  data-memory write enable.
- `ALUSrc`  out  1  0 = rs2, 1 = immediate.
- `RegWrite`  out  1  register-file write enable.
- `ResultSrc`  out  2  00 = ALU, 01 = memory, 10 = PC+4, 11 = unused.
- `immSrc`  out  2  00 = I, 01 = S, 10 = B, 11 = J.
- `ALUControl`  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.

## Operation
- Main decode (combinational):
  - lw 0000011: RegWrite=1, ALUSrc=1, immSrc=00, ResultSrc=01, ALUOp=00.
  - sw 0100011: MemWrite=1, ALUSrc=1, immSrc=01, ALUOp=00.
  - R-type 0110011: RegWrite=1, ALUSrc=0, ResultSrc=00, ALUOp=10.
  - I-ALU 0010011: RegWrite=1, ALUSrc=1, immSrc=00, ResultSrc=00, ALUOp=10.
  - branch 1100011: Branch=1, immSrc=10, ALUSrc=0, ALUOp=01.
  - jal 1101111: Jump=1, RegWrite=1, immSrc=11, ResultSrc=10.
  - All unlisted fields are 0.
- ALU decode:
  - ALUOp 00 gives add; 01 gives sub.
  - ALUOp 10 selects by funct3:
    - 000: sub if opcode[5]=1 and funct7_5=1, else add. An I-type with funct7_5=1 is add.
    - 010: slt. 100: xor. 110: or. 111: and.
    - Any other funct3: add.
- Branch sense: funct3 000 = beq (take on zeroFlag=1); 001 = bne (take on zeroFlag=0). Any other branch funct3 is never taken.
- Illegal or unsupported opcode decodes as a NOP: every output 0, ALUControl=000.
- `PCSrc = Jump_q | (Branch_q & (zeroFlag ^ bne_q))`, where the `_q` signals are registered.

## Timing
- All decoded controls, including Branch/Jump/bne, are registered on the rising `clk` edge. Latency from inputs to outputs is 1 cycle.
- `PCSrc` is combinational from the registered Branch/Jump/bne and the current-cycle `zeroFlag`. It has no extra latency relative to `zeroFlag`.
- Reset: when `rst_n`=0 at a rising edge, every register clears. All outputs then read 0, ALUControl=000, and PCSrc=0 regardless of `zeroFlag`.
- Reset asserted mid-stream discards the instruction in flight. The first instruction presented with `rst_n`=1 appears at the outputs one edge later.
- Outputs before the first clock edge are don't-care.
- Back-to-back instructions are accepted every cycle with no stalls or bubbles.

## Structure
- Package `control_pkg`:
  - opcode localparams: OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL.
  - enums: `alu_ctrl_e` (3-bit), `imm_src_e`, `result_src_e`, `alu_op_e` (2-bit).
- Sub-module `alu_decoder`: combinational; inputs ALUOp, funct3, opcode[5], funct7_5; output ALUControl.
- The main decoder, pipeline register and PCSrc logic live in `control_unit`.

## Test plan
- Reset: hold `rst_n`=0 for 2 edges with any instruction applied → all outputs 0 and PCSrc=0, even with zeroFlag=1.
- lw (0xFFC4A303), one edge after rst_n=1 → RegWrite=1, ALUSrc=1, immSrc=00, ResultSrc=01, MemWrite=0, ALUControl=000, PCSrc=0.
- sw (0x0064A423) → MemWrite=1, ALUSrc=1, immSrc=01, RegWrite=0, ALUControl=000, PCSrc=0.
- or (0x0062E233) → RegWrite=1, ALUSrc=0, ResultSrc=00, ALUControl=011, MemWrite=0.
- beq (0xFE420AE3):
  - zeroFlag=1 → PCSrc=1, immSrc=10, ALUControl=001, RegWrite=0, MemWrite=0.
  - toggle zeroFlag to 0 in the same cycle → PCSrc=0.
- sub (0x40000033) → ALUControl=001; addi with instr[30]=1 → ALUControl=000.
- jal (0x0000006F) → PCSrc=1, RegWrite=1, ResultSrc=10, immSrc=11.
- Opcode 0x7F → all outputs 0.
